// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared types and constants for the uart_tx_arbiter slice
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HEADER = 2'd1,
        ARB_STREAM = 2'd2
    } arb_state_e;

    localparam logic [3:0] HDR_MARK        = 4'hA;
    localparam int         STATUS_FULL_BIT = 1;
    localparam int         STATUS_ERR_BIT  = 0;

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin search: first set req bit at or after ptr, cyclically
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    always_comb begin
        int idx;
        idx      = 0;
        grant_id = '0;
        any      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst arbiter feeding one uart_transmitter byte port
// Optional header byte per grant when UART_TX_ARB_HEADER_EN is defined.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [7:0]                   tx_status,
    output logic                         write_data,
    output logic [DATA_SIZE-1:0]         bus_data,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy,
    output logic [7:0]                   err_count
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    arb_state_e          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                err_prev;

    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic                full;
    logic                err_bit;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_SIZE-1:0] sel_data;
    logic                hs;
    logic [ID_W-1:0]     next_ptr;
    logic                status_unused;

    assign full          = tx_status[STATUS_FULL_BIT];
    assign err_bit       = tx_status[STATUS_ERR_BIT];
    assign status_unused = ^tx_status[7:2];

    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign sel_data  = req_data[int'(grant_id)*DATA_SIZE +: DATA_SIZE];
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign busy      = (state != ARB_IDLE);

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant_id (pick_id),
        .any      (pick_any)
    );

`ifdef UART_TX_ARB_HEADER_EN
    logic [3:0] hdr_id;
    assign hdr_id = 4'(grant_id);
`endif

    // Strobes are gated by reset so an aborted burst cannot emit a byte in the reset cycle.
    always_comb begin
        req_ready  = '0;
        write_data = 1'b0;
        bus_data   = '0;
        hs         = 1'b0;
        if (!reset) begin
            case (state)
                ARB_STREAM: begin
                    req_ready[grant_id] = ~full;
                    hs                  = sel_valid & ~full;
                    write_data          = hs;
                    if (hs) begin
                        bus_data = sel_data;
                    end
                end
`ifdef UART_TX_ARB_HEADER_EN
                ARB_HEADER: begin
                    write_data = ~full;
                    if (!full) begin
                        bus_data = DATA_SIZE'({HDR_MARK, hdr_id});
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            idle_cnt  <= '0;
            err_count <= '0;
            err_prev  <= 1'b0;
        end else begin
            err_prev <= err_bit;
            if (err_bit && !err_prev && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
`ifdef UART_TX_ARB_HEADER_EN
                        state    <= ARB_HEADER;
`else
                        state    <= ARB_STREAM;
`endif
                    end
                end
`ifdef UART_TX_ARB_HEADER_EN
                ARB_HEADER: begin
                    if (!full) begin
                        state <= ARB_STREAM;
                    end
                end
`endif
                ARB_STREAM: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        idle_cnt <= '0;
                        if (sel_last || (beat_cnt == BEAT_W'(MAX_BURST - 1))) begin
                            state  <= ARB_IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end else if (!sel_valid) begin
                        // Only a silent requester ages; a full FIFO stall leaves idle_cnt alone.
                        if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                            state  <= ARB_IDLE;
                            rr_ptr <= next_ptr;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic           clk;
    logic           reset;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_last;
    logic [NR-1:0]  req_ready;
    logic [7:0]     tx_status;
    logic           write_data;
    logic [DW-1:0]  bus_data;
    logic [1:0]     grant_id;
    logic           busy;
    logic [7:0]     err_count;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .DATA_SIZE (DW),
        .MAX_BURST (16),
        .TIMEOUT   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_status  (tx_status),
        .write_data (write_data),
        .bus_data   (bus_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int cyc;

    logic [8:0] src_mem [NR][64];
    int         src_head [NR];
    int         src_tail [NR];

    logic [7:0] wr_data [64];
    logic [1:0] wr_gid  [64];
    int         wr_cyc  [64];
    int         wr_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (src_head[i] < src_tail[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = src_mem[i][src_head[i]][7:0];
                req_last[i]           = src_mem[i][src_head[i]][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        src_mem[r][src_tail[r]] = {last, d};
        src_tail[r]++;
        drive_inputs();
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < NR; i++) begin
            if (src_head[i] < src_tail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step();
        logic [NR-1:0] hs_s;
        @(negedge clk);
        cyc++;
        if (write_data && wr_n < 64) begin
            wr_data[wr_n] = bus_data;
            wr_gid[wr_n]  = grant_id;
            wr_cyc[wr_n]  = cyc;
            wr_n++;
        end
        if (tx_status[1]) begin
            check_eq("full_write", write_data, 0);
            check_eq("full_ready", req_ready, 0);
        end
        hs_s = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs_s[i]) src_head[i]++;
        end
        drive_inputs();
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NR; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        tx_status = 8'h00;
        clear_sources();
        step();
        step();
        reset = 1'b0;
        wr_n  = 0;
    endtask

    task automatic run_until_idle(input int maxc);
        int  n;
        logic done;
        n = 0;
        while ((!sources_empty() || busy) && n < maxc) begin
            step();
            n++;
        end
        done = sources_empty() && !busy;
        check_eq("run_done", done, 1);
    endtask

    initial begin
        int n0;
        total     = 0;
        bad       = 0;
        cyc       = 0;
        wr_n      = 0;
        reset     = 1'b1;
        tx_status = 8'h00;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        @(posedge clk);
        #1;
        do_reset();

        check_eq("rst_busy", busy, 0);
        check_eq("rst_write", write_data, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_bus", bus_data, 0);
        check_eq("rst_gid", grant_id, 0);
        check_eq("rst_err", err_count, 0);

        // single requester burst
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        run_until_idle(20);
        check_eq("t1_n", wr_n, 3);
        check_eq("t1_d0", wr_data[0], 8'h11);
        check_eq("t1_d1", wr_data[1], 8'h22);
        check_eq("t1_d2", wr_data[2], 8'h33);
        check_eq("t1_gid", wr_gid[2], 1);
        check_eq("t1_span", wr_cyc[2] - wr_cyc[0], 2);
        check_eq("t1_busy", busy, 0);

        // pointer now at 2: req2 wins over req0
        wr_n = 0;
        push(0, 8'hA0, 1'b1);
        push(2, 8'hA2, 1'b1);
        run_until_idle(20);
        check_eq("t1_ptr_n", wr_n, 2);
        check_eq("t1_ptr_g0", wr_gid[0], 2);
        check_eq("t1_ptr_d0", wr_data[0], 8'hA2);
        check_eq("t1_ptr_g1", wr_gid[1], 0);

        // four 1-byte bursts, twice
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            wr_n = 0;
            for (int i = 0; i < NR; i++) push(i, 8'(8'h20 + rep*16 + i), 1'b1);
            run_until_idle(30);
            check_eq("t2_n", wr_n, 4);
            for (int k = 0; k < 4; k++) begin
                check_eq("t2_gid", wr_gid[k], k);
                check_eq("t2_data", wr_data[k], 8'(8'h20 + rep*16 + k));
                if (k > 0) check_eq("t2_gap", wr_cyc[k] - wr_cyc[k-1], 2);
            end
        end

        // 40-byte stream capped at 16 per grant
        do_reset();
        for (int i = 0; i < 40; i++) push(2, 8'(8'h40 + i), 1'b0);
        step();
        step();
        push(3, 8'hE3, 1'b1);
        push(0, 8'hE0, 1'b1);
        run_until_idle(300);
        check_eq("t3_n", wr_n, 42);
        for (int k = 0; k < 42; k++) begin
            if (k < 16) begin
                check_eq("t3_data", wr_data[k], 8'(8'h40 + k));
                check_eq("t3_gid", wr_gid[k], 2);
            end else if (k == 16) begin
                check_eq("t3_data", wr_data[k], 8'hE3);
                check_eq("t3_gid", wr_gid[k], 3);
            end else if (k == 17) begin
                check_eq("t3_data", wr_data[k], 8'hE0);
                check_eq("t3_gid", wr_gid[k], 0);
            end else begin
                check_eq("t3_data", wr_data[k], 8'(8'h40 + k - 2));
                check_eq("t3_gid", wr_gid[k], 2);
            end
        end

        // FIFO full stall longer than the timeout
        do_reset();
        for (int i = 0; i < 6; i++) push(1, 8'(8'h61 + i), (i == 5));
        for (int n = 0; n < 10 && wr_n < 2; n++) step();
        check_eq("t4_pre", wr_n, 2);
        tx_status[1] = 1'b1;
        repeat (10) step();
        check_eq("t4_busy", busy, 1);
        check_eq("t4_gid", grant_id, 1);
        tx_status[1] = 1'b0;
        run_until_idle(30);
        check_eq("t4_n", wr_n, 6);
        for (int k = 0; k < 6; k++) check_eq("t4_data", wr_data[k], 8'(8'h61 + k));

        // silent requester times out, pending req3 next
        do_reset();
        push(0, 8'h50, 1'b0);
        push(0, 8'h51, 1'b0);
        push(3, 8'h53, 1'b1);
        run_until_idle(40);
        check_eq("t5_n", wr_n, 3);
        check_eq("t5_d1", wr_data[1], 8'h51);
        check_eq("t5_g2", wr_gid[2], 3);
        check_eq("t5_d2", wr_data[2], 8'h53);
        check_eq("t5_release", wr_cyc[2] - wr_cyc[1], 10);

        for (int i = 0; i < 3; i++) begin
            tx_status[0] = 1'b1;
            step();
            tx_status[0] = 1'b0;
            step();
        end
        check_eq("t5_err3", err_count, 3);
        for (int i = 0; i < 260; i++) begin
            tx_status[0] = 1'b1;
            step();
            tx_status[0] = 1'b0;
            step();
        end
        check_eq("t5_err_sat", err_count, 8'hFF);

        // header (when enabled) and mid-burst reset
        do_reset();
        push(3, 8'h5C, 1'b1);
        run_until_idle(20);
`ifdef UART_TX_ARB_HEADER_EN
        check_eq("t6_n", wr_n, 2);
        check_eq("t6_hdr", wr_data[0], 8'hA3);
        check_eq("t6_hdr_gid", wr_gid[0], 3);
        check_eq("t6_data", wr_data[1], 8'h5C);
`else
        check_eq("t6_n", wr_n, 1);
        check_eq("t6_data", wr_data[0], 8'h5C);
`endif
        wr_n = 0;
        for (int i = 0; i < 4; i++) push(1, 8'(8'h71 + i), (i == 3));
        for (int n = 0; n < 10 && wr_n < 2; n++) step();
        check_eq("t6_mid_busy", busy, 1);
        n0    = wr_n;
        reset = 1'b1;
        step();
        check_eq("t6_rst_nowr", wr_n, n0);
        check_eq("t6_rst_write", write_data, 0);
        check_eq("t6_rst_ready", req_ready, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_bus", bus_data, 0);
        check_eq("t6_rst_gid", grant_id, 0);
        reset = 1'b0;
        clear_sources();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
